rapid_mem_stage: RTL
====================

# rapid_mem_stage

Memory stage of the rapid RISC-V pipeline: accepts one instruction per handshake from the execute stage, issues loads/stores to the data memory over a request/grant/response port, formats load data, and presents a registered writeback record. Non-memory instructions pass through with one cycle of latency. While a memory access is outstanding the stage deasserts its ready signal, which stalls execute.

## Interface
- ADDR_W, 32, data-memory address width (low ADDR_W bits of i_alu_result)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute presents an instruction
- o_ready  out  1  stage accepts the instruction this cycle
- i_mem_read / i_mem_write  in  1 each  load / store (never both)
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_reg_write  in  1  instruction writes rd
- i_rd  in  5  destination register
- i_alu_result  in  32  address for memory ops, result otherwise
- i_store_data  in  32  rs2 value for stores
- o_dmem_req  out  1  request valid, held until granted
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  ADDR_W  byte address
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load data, aligned word
- o_wb_valid  out  1  writeback record valid (one-cycle pulse per instruction)
- o_wb_we  out  1  register-file write enable
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  result / formatted load data
- o_misaligned  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM: IDLE, REQ, WAIT. o_ready = (state == IDLE).
- IDLE, i_valid, no memory op: register writeback record; o_wb_valid=1 next cycle, o_wb_we=i_reg_write && i_rd!=0, o_wb_data=i_alu_result.
- IDLE, i_valid, memory op: latch addr/be/wdata/funct3/rd → REQ.
- REQ: o_dmem_req=1, outputs stable until i_dmem_gnt. On gnt: store → IDLE, wb record (o_wb_we=0) next cycle; load → WAIT.
- WAIT: on i_dmem_rvalid → IDLE, wb record next cycle with formatted data, o_wb_we=(rd!=0).
- Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- Store data: B byte replicated ×4; H halfword ×2; W as is.
- Load format: select byte/half by addr[1:0]; sign-extend for 000/001, zero-extend for 100/101.
- i_dmem_rvalid outside WAIT is ignored.
- Reset values: state IDLE; o_dmem_req, o_dmem_we, o_wb_valid, o_wb_we, o_misaligned = 0; o_dmem_addr, o_dmem_be, o_dmem_wdata, o_wb_rd, o_wb_data = 0.

## Timing
- Pass-through latency: 1 cycle, throughput 1/cycle.
- Store: accept at T, o_dmem_req from T+1, gnt at G, o_wb_valid at G+1; o_ready returns at G+1.
- Load: rvalid at R (≥ G+1), o_wb_valid and o_ready at R+1.
- Reset mid-access: req drops immediately, FSM to IDLE, in-flight response ignored, no writeback.

## Configuration
- RAPID_MEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 issues no request; o_misaligned pulses one cycle after accept, alongside o_wb_valid=1 with o_wb_we=0; stage stays in IDLE.
- Not defined: o_misaligned tied 0; address low bits forced to alignment (H clears bit 0, W clears bits 1:0) and access proceeds normally.

## Test plan
- ALU op rd=5, result 0x1234_5678 → next cycle o_wb_valid=1, o_wb_we=1, o_wb_rd=5, o_wb_data=0x1234_5678; back-to-back ops each 1 cycle.
- SB addr 0x103, data 0xAB, gnt after 2 wait cycles → o_dmem_be=1000, o_dmem_wdata=0xABABABAB held 3 cycles; o_wb_valid=1, o_wb_we=0 cycle after gnt.
- LB addr 0x102, rdata 0x0080_0000 → o_wb_data=0xFFFF_FF80; LBU same → 0x0000_0080; LH addr 0x102, rdata 0x8001_0000 → 0xFFFF_8001.
- LW rd=0 → access completes, o_wb_we=0; spurious rvalid in IDLE produces no writeback.
- Assert i_rst_n low while in WAIT → o_dmem_req=0, state IDLE; later rvalid ignored, o_ready=1.
- LW addr 0x101: with macro → no req, o_misaligned pulse; without → o_dmem_addr=0x100, be=1111.

Source files
------------

// File: rtl/rapid_mem_stage_if.sv
// Execute-side, data-memory and writeback signals of the rapid memory stage.
interface rapid_mem_stage_if #(parameter int ADDR_W = 32);
  logic              valid;
  logic              ready;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic              reg_write;
  logic [4:0]        rd;
  logic [31:0]       alu_result;
  logic [31:0]       store_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              misaligned;

  modport slave (
    input  valid, mem_read, mem_write, funct3, reg_write, rd, alu_result, store_data,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, misaligned
  );

  modport master (
    output valid, mem_read, mem_write, funct3, reg_write, rd, alu_result, store_data,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, misaligned
  );
endinterface

// File: rtl/rapid_mem_stage.sv
// Memory stage: 1-cycle pass-through; loads/stores hold ready low until granted/answered.
// Define RAPID_MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module rapid_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rapid_mem_stage_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              misal_q;

  logic              is_mem;
  logic              trap;
  logic [1:0]        sz;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_use;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign is_mem         = bus.mem_read | bus.mem_write;
  assign sz             = bus.funct3[1:0];
  assign addr_in        = bus.alu_result[ADDR_W-1:0];
  assign bus.ready      = (state == IDLE);
  assign bus.misaligned = misal_q;

`ifdef RAPID_MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && ((sz == 2'b01 && addr_in[0]) ||
                           (sz == 2'b10 && addr_in[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    addr_use = addr_in;
`ifndef RAPID_MEM_MISALIGN_TRAP_EN
    // Without the trap, misaligned halfword/word accesses are silently aligned down.
    if (sz == 2'b01) addr_use[0] = 1'b0;
    else if (sz == 2'b10) addr_use[1:0] = 2'b00;
`endif
    case (sz)
      2'b00:   be_in = 4'b0001 << addr_use[1:0];
      2'b01:   be_in = 4'b0011 << addr_use[1:0];
      default: be_in = 4'b1111;
    endcase
    case (sz)
      2'b00:   wdata_in = {4{bus.store_data[7:0]}};
      2'b01:   wdata_in = {2{bus.store_data[15:0]}};
      default: wdata_in = bus.store_data;
    endcase
  end

  always_comb begin
    case (bus.dmem_addr[1:0])
      2'd0:    ld_byte = bus.dmem_rdata[7:0];
      2'd1:    ld_byte = bus.dmem_rdata[15:8];
      2'd2:    ld_byte = bus.dmem_rdata[23:16];
      default: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = bus.dmem_addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      misal_q        <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= 4'd0;
      bus.dmem_wdata <= 32'd0;
      bus.wb_valid   <= 1'b0;
      bus.wb_we      <= 1'b0;
      bus.wb_rd      <= 5'd0;
      bus.wb_data    <= 32'd0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.wb_we    <= 1'b0;
      misal_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            if (!is_mem || trap) begin
              // Trapped accesses retire as a non-writing record tagged by o_misaligned.
              bus.wb_valid <= 1'b1;
              bus.wb_we    <= !is_mem && bus.reg_write && (bus.rd != 5'd0);
              bus.wb_rd    <= bus.rd;
              bus.wb_data  <= bus.alu_result;
              misal_q      <= trap;
            end else begin
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.mem_write;
              bus.dmem_addr  <= addr_use;
              bus.dmem_be    <= be_in;
              bus.dmem_wdata <= wdata_in;
              funct3_q       <= bus.funct3;
              rd_q           <= bus.rd;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dmem_gnt) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (bus.dmem_we) begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_q;
              bus.wb_data  <= 32'd0;
              state        <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.dmem_rvalid) begin
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= (rd_q != 5'd0);
            bus.wb_rd    <= rd_q;
            bus.wb_data  <= ld_data;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
